// File: rtl/sap_1_program_loader_pkg.sv
// sap_1_defs: shared SAP-1 widths, loader state encoding and opcode constants
package sap_1_defs;
  localparam int SAP_1_ADDR_WIDTH = 4;
  localparam int SAP_1_DATA_WIDTH = 8;
  typedef enum logic [2:0] {IDLE, LOAD, VERIFY, RUN, ERR} state_t;
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;
  function automatic logic [7:0] sap_1_instr(input logic [3:0] op, input logic [3:0] arg);
    return {op, arg};
  endfunction
endpackage

// File: rtl/sap_1_program_loader_sum_accumulator.sv
// sap_1_sum_accumulator: wrapping byte sum with synchronous clear and enable
module sap_1_sum_accumulator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] sum
);
  always_ff @(posedge clk or posedge rst)
    if (rst) sum <= '0;
    else if (clr) sum <= '0;
    else if (en) sum <= sum + d;
endmodule

// File: rtl/sap_1_program_loader.sv
// sap_1_program_loader: streams a program into SAP-1 RAM, verifies it by readback sum, then releases the CPU
module sap_1_program_loader
  import sap_1_defs::*;
#(
  parameter int ADDR_WIDTH = SAP_1_ADDR_WIDTH,
  parameter int DATA_WIDTH = SAP_1_DATA_WIDTH,
  parameter int WORDS = 16
) (
  input  logic                  Clk,
  input  logic                  Clr,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  cpu_clr,
  output logic                  done,
  output logic                  error
);
  localparam int VW = $clog2(WORDS + 2);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(WORDS - 1);
  localparam logic [VW-1:0] VLAST = VW'(WORDS - 1);
  localparam logic [VW-1:0] VEND = VW'(WORDS);
  state_t state, state_d;
  logic [ADDR_WIDTH-1:0] index, index_d, addr_d;
  logic [VW-1:0] vcnt, vcnt_d;
  logic [DATA_WIDTH-1:0] wsum, rsum, rsum_next, wdata_d;
  logic beat, go, last, fin, ok, ready_d, we_d, cpu_clr_d, done_d, error_d;
  assign beat = in_valid & in_ready;
  assign go = start & (state inside {IDLE, RUN, ERR});
  // the final write cycle is the only LOAD cycle with ram_we high and in_ready low
  assign last = (state == LOAD) & ram_we & ~in_ready;
  assign fin = (state == VERIFY) & (vcnt == VEND);
  assign rsum_next = rsum + ram_rdata;
  assign ok = rsum_next == wsum;
  sap_1_sum_accumulator #(.WIDTH(DATA_WIDTH)) u_wsum (
    .clk(Clk), .rst(Clr), .clr(go), .en(beat), .d(in_data), .sum(wsum)
  );
  // read data lags the address by one cycle, so accumulation starts at vcnt=1
  sap_1_sum_accumulator #(.WIDTH(DATA_WIDTH)) u_rsum (
    .clk(Clk), .rst(Clr), .clr(go | last), .en((state == VERIFY) & (vcnt != '0)),
    .d(ram_rdata), .sum(rsum)
  );
  always_ff @(posedge Clk or posedge Clr)
    if (Clr) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    if (go) state_d = LOAD;
    else if (last) state_d = VERIFY;
    else if (fin) state_d = ok ? RUN : ERR;
  end
  always_comb begin
    ready_d = go ? 1'b1 : (beat && index == LAST_IDX) ? 1'b0 : in_ready;
    we_d = beat;
    wdata_d = beat ? in_data : ram_wdata;
    addr_d = beat ? index : last ? '0 :
             (state == VERIFY && vcnt < VLAST) ? ram_addr + 1'b1 : ram_addr;
    index_d = go ? '0 : (beat && index != LAST_IDX) ? index + 1'b1 : index;
    vcnt_d = last ? '0 : (state == VERIFY) ? vcnt + 1'b1 : vcnt;
    cpu_clr_d = state_d != RUN;
    done_d = state_d == RUN;
    error_d = state_d == ERR;
  end
  always_ff @(posedge Clk or posedge Clr)
    if (Clr) begin
      in_ready <= 1'b0;
      ram_we <= 1'b0;
      ram_addr <= '0;
      ram_wdata <= '0;
      cpu_clr <= 1'b1;
      done <= 1'b0;
      error <= 1'b0;
      index <= '0;
      vcnt <= '0;
    end else begin
      in_ready <= ready_d;
      ram_we <= we_d;
      ram_addr <= addr_d;
      ram_wdata <= wdata_d;
      cpu_clr <= cpu_clr_d;
      done <= done_d;
      error <= error_d;
      index <= index_d;
      vcnt <= vcnt_d;
    end
endmodule

// File: tb/tb_sap_1_program_loader.sv
// tb_sap_1_program_loader: directed vectors and corner sequences for the SAP-1 program loader
module tb_sap_1_program_loader;
  import sap_1_defs::*;
  logic Clk = 1'b0, Clr = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = 8'h00, ram_wdata, ram_rdata = 8'h00;
  logic [3:0] ram_addr;
  logic in_ready, ram_we, cpu_clr, done, error;
  logic [7:0] mem [16];
  logic [7:0] prog [16];
  logic [7:0] prog_a [16];
  bit corrupt = 1'b0, scrub = 1'b0;
  int tests = 0, fails = 0;
  localparam logic [16:0] RST_VEC = {1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0};
  typedef struct {
    bit toggle;
    bit corrupt;
    bit all_ff;
    int poke;
    bit exp_done;
    bit exp_err;
  } vec_t;
  vec_t vecs [5];
  sap_1_program_loader dut (
    .Clk(Clk), .Clr(Clr), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .cpu_clr(cpu_clr), .done(done), .error(error)
  );
  always #5 Clk = ~Clk;
  always @(posedge Clk) begin
    if (scrub) for (int a = 0; a < 16; a++) mem[a] <= 8'h77;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= (corrupt && ram_addr == 4'd5) ? 8'hFF : mem[ram_addr];
  end
  function automatic logic [16:0] out_vec();
    return {in_ready, ram_we, ram_addr, ram_wdata, cpu_clr, done, error};
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic do_load(input bit toggle, input int poke, output int writes, output int bad, output int lat);
    int k = 0;
    int last_we = -1;
    bit beat = 1'b0, prev_beat = 1'b0;
    writes = 0;
    bad = 0;
    lat = -1;
    scrub = 1'b1;
    @(negedge Clk);
    scrub = 1'b0;
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    for (int t = 0; t < 300 && lat < 0; t++) begin
      if (ram_we !== prev_beat) bad++;
      if (ram_we) begin
        if (writes >= 16 || ram_addr !== 4'(writes) || ram_wdata !== prog[writes[3:0]]) bad++;
        writes++;
        last_we = t;
      end
      if ((done || error) && last_we >= 0) lat = t - last_we;
      start = poke >= 0 && writes == 16 && t == last_we + poke;
      in_valid = k < 16 && (!toggle || t[0]);
      in_data = k < 16 ? prog[k] : 8'h00;
      beat = in_valid && in_ready;
      @(negedge Clk);
      prev_beat = beat;
      if (beat) k++;
    end
    in_valid = 1'b0;
    start = 1'b0;
  endtask
  task automatic check_load(input string tag, input bit exp_done, input bit exp_err);
    int writes, bad, lat, mm;
    do_load(1'b0, -1, writes, bad, lat);
    mm = 0;
    for (int a = 0; a < 16; a++) if (mem[a] !== prog[a]) mm++;
    chk({tag, " writes"}, writes, 16);
    chk({tag, " write order"}, bad, 0);
    chk({tag, " ram contents"}, mm, 0);
    chk({tag, " done latency"}, lat, 18);
    chk({tag, " done/err/clr"}, {done, error, cpu_clr}, {exp_done, exp_err, !exp_done});
  endtask
  initial begin
    int writes, bad, lat, mm;
    prog_a = '{sap_1_instr(OP_LDA, 4'h9), sap_1_instr(OP_ADD, 4'hA), sap_1_instr(OP_SUB, 4'hB),
               sap_1_instr(OP_OUT, 4'h0), sap_1_instr(OP_HLT, 4'h0), 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h10, 8'h14, 8'h18, 8'h20, 8'h00};
    vecs[0] = '{1'b0, 1'b0, 1'b0, -1, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, -1, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 1'b1, -1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 6, 1'b1, 1'b0};
    repeat (2) @(negedge Clk);
    chk("reset outputs", int'(out_vec()), int'(RST_VEC));
    Clr = 1'b0;
    @(negedge Clk);
    chk("idle outputs", int'(out_vec()), int'(RST_VEC));
    for (int i = 0; i < 5; i++) begin
      for (int a = 0; a < 16; a++) prog[a] = vecs[i].all_ff ? 8'hFF : prog_a[a];
      corrupt = vecs[i].corrupt;
      do_load(vecs[i].toggle, vecs[i].poke, writes, bad, lat);
      mm = 0;
      for (int a = 0; a < 16; a++) if (mem[a] !== prog[a]) mm++;
      chk($sformatf("v%0d writes", i), writes, 16);
      chk($sformatf("v%0d write timing", i), bad, 0);
      chk($sformatf("v%0d ram contents", i), mm, 0);
      chk($sformatf("v%0d finished", i), int'(lat >= 0), 1);
      if (vecs[i].exp_done) chk($sformatf("v%0d done latency", i), lat, 18);
      chk($sformatf("v%0d done/err/clr", i), {done, error, cpu_clr},
          {vecs[i].exp_done, vecs[i].exp_err, !vecs[i].exp_done});
      corrupt = 1'b0;
    end
    chk("run before restart", {done, cpu_clr}, 2'b10);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    chk("restart from run clr/ready/done", {cpu_clr, in_ready, done}, 3'b110);
    check_load("restart", 1'b1, 1'b0);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_data = prog[i];
      @(negedge Clk);
    end
    chk("pre-clr write", {ram_we, ram_addr}, {1'b1, 4'h6});
    Clr = 1'b1;
    #1;
    chk("async clr outputs", int'(out_vec()), int'(RST_VEC));
    in_valid = 1'b0;
    @(negedge Clk);
    Clr = 1'b0;
    @(negedge Clk);
    check_load("after clr", 1'b1, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sap_1_program_loader.md
Name: sap_1_program_loader

Overview:
- Writer side of the SAP-1 program RAM: fills the 16x8 RAM from a byte stream that the CPU later fetches from.
- Holds the CPU in clear while loading, then reads every word back and checks it against a running sum.
- Releases the CPU to run only if the check passes.
- Sits between a host/bench byte source and the RAM write port inside the SAP-1 top level.

Parameters:
- ADDR_WIDTH, 4, RAM address width.
- DATA_WIDTH, 8, RAM word / stream byte width.
- WORDS, 16, words loaded per program; must be ≤ 2**ADDR_WIDTH.

Ports:
- Clk  input  1  system clock, rising edge.
- Clr  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load in IDLE, RUN or ERR.
- in_valid  input  1  stream byte valid.
- in_data  input  DATA_WIDTH  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- ram_addr  output  ADDR_WIDTH  RAM address for write and readback.
- ram_wdata  output  DATA_WIDTH  RAM write data.
- ram_we  output  1  RAM write enable, one cycle per word.
- ram_rdata  input  DATA_WIDTH  RAM read data, synchronous, valid 1 cycle after ram_addr with ram_we=0.
- cpu_clr  output  1  drives the SAP-1 Clr; 1 = CPU held in clear.
- done  output  1  load verified; CPU running.
- error  output  1  readback sum mismatch.

Behaviour:
- All outputs are registered.
- Reset (Clr=1, asynchronous):
  - state=IDLE.
  - in_ready=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - cpu_clr=1, done=0, error=0.
  - wsum=0, rsum=0, index=0.
- IDLE: cpu_clr=1. On start, go to LOAD: index=0, wsum=0, done=0, error=0, in_ready=1.
- LOAD:
  - A beat occurs on a rising edge with in_valid&in_ready=1.
  - In the cycle after a beat: ram_we=1, ram_addr=index, ram_wdata=in_data. Then index++ and wsum=(wsum+in_data) mod 2**DATA_WIDTH.
  - Back-to-back beats are allowed: one write per cycle, so ram_we may stay high across consecutive cycles.
  - in_ready falls at the same edge that accepts beat WORDS-1; no further bytes are taken.
  - in_valid while in_ready=0 is ignored; data is not consumed.
- VERIFY:
  - Entered the cycle after the last write.
  - ram_we=0; ram_addr steps 0..WORDS-1 on consecutive cycles.
  - rsum accumulates ram_rdata with a one-cycle lag.
  - After WORDS reads plus one cycle, compare rsum with wsum.
  - Equal: go to RUN. Otherwise go to ERR.
- Done latency: done rises exactly WORDS+2 cycles after the last ram_we cycle.
- RUN: done=1, cpu_clr=0. Held until start (restarts a LOAD, cpu_clr=1 at the next edge) or Clr.
- ERR: error=1, cpu_clr=1. Held until start or Clr.
- start during LOAD or VERIFY is ignored.
- Clr mid-load or mid-verify: immediate return to reset values, cpu_clr=1 asynchronously. Partially written RAM contents are not cleared.
- Sums wrap modulo 2**DATA_WIDTH; carries are discarded.
- Index wrap: index never exceeds WORDS-1. With WORDS < 2**ADDR_WIDTH, upper addresses are untouched.

Decomposition:
- Shared package/header sap_1_defs:
  - State encodings IDLE, LOAD, VERIFY, RUN, ERR.
  - SAP_1_ADDR_WIDTH=4, SAP_1_DATA_WIDTH=8.
  - SAP-1 opcode constants used by benches to build programs.
- One natural sub-module: sap_1_sum_accumulator (clear, enable, data in, wrapping sum out), instantiated twice for wsum and rsum.

Test Plan:
1. Load program 0x09,0x1A,0x2B,0xE0,0xF0, then 0x00 x6, then 0x10,0x14,0x18,0x20,0x00, with in_valid held high -> 16 consecutive ram_we cycles at addrs 0..15. done=1 and cpu_clr=0 exactly 18 cycles after the last write.
2. Same program with in_valid toggling every other cycle -> writes occur only after accepted beats; final RAM contents and done are identical.
3. Bench RAM model corrupts address 5 (reads back 0xFF instead of 0x00) -> error=1, done=0, cpu_clr stays 1.
4. Assert Clr at beat 7 of LOAD -> outputs return to reset values within the same cycle (async). A following start plus a full 16-byte load succeeds.
5. Pulse start during VERIFY -> ignored; normal done. Pulse start in RUN -> cpu_clr=1 the next cycle, in_ready=1, new load proceeds.
6. Bytes 0xFF x16 -> wsum wraps to 0xF0; verify passes; done=1.
